// File: rtl/kiwi_wf_ctrl.sv
// -----------------------------------------------------------------------------
// kiwi_wf_ctrl -- waterfall zoom / capture controller
//
// Sits between a zoom-level request stream, the config port of a CIC
// decimator and a frame sink. A zoom request reprograms the CIC decimation
// word. The controller then throws away the CIC's settling samples and waits
// in READY. A start pulse then captures one frame of FRAME_LEN samples.
//
// Ports
//   aclk                  sole clock; every flop uses its rising edge
//   reset                 synchronous, active-high
//   s_axis_zoom_*         4-bit zoom request stream (tdata/tvalid/tready)
//   m_axis_config_*       decimation word 2^(zoom+1) to the CIC config port
//   cic_tdata/cic_tvalid  CIC output samples, single-cycle strobe, no backpressure
//   m_axis_data_*         captured samples, tlast on the last sample of a frame
//   start                 capture request, acted on only in READY
//   busy                  high in every state except READY
//   zoom                  zoom level currently applied
// -----------------------------------------------------------------------------
module kiwi_wf_ctrl #(
  parameter int ZOOM_MAX      = 13,
  parameter int OUT_WIDTH     = 16,
  parameter int CFG_WIDTH     = 24,
  parameter int FLUSH_SAMPLES = 6,
  parameter int FRAME_LEN     = 1024
) (
  input  logic                 aclk,
  input  logic                 reset,

  input  logic [3:0]           s_axis_zoom_tdata,
  input  logic                 s_axis_zoom_tvalid,
  output logic                 s_axis_zoom_tready,

  output logic [CFG_WIDTH-1:0] m_axis_config_tdata,
  output logic                 m_axis_config_tvalid,
  input  logic                 m_axis_config_tready,

  input  logic [OUT_WIDTH-1:0] cic_tdata,
  input  logic                 cic_tvalid,

  output logic [OUT_WIDTH-1:0] m_axis_data_tdata,
  output logic                 m_axis_data_tvalid,
  output logic                 m_axis_data_tlast,

  input  logic                 start,
  output logic                 busy,
  output logic [3:0]           zoom
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_READY   = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

  // Counter widths are chosen so the terminal count itself fits, so a counter
  // never wraps before it is compared.
  localparam int FCW = $clog2(FLUSH_SAMPLES + 1);
  localparam int SCW = $clog2(FRAME_LEN + 1);

  localparam logic [FCW-1:0]       FLUSH_LAST = FCW'(FLUSH_SAMPLES);
  localparam logic [SCW-1:0]       FRAME_LAST = SCW'(FRAME_LEN);
  localparam logic [3:0]           ZOOM_MAX_C = 4'(ZOOM_MAX);
  localparam logic [3:0]           ZOOM_RESET = 4'd4;
  localparam logic [CFG_WIDTH-1:0] CFG_ONE    = CFG_WIDTH'(1);

  state_e               state_q,      state_d;
  logic [3:0]           zoom_q,       zoom_d;
  logic [FCW-1:0]       flush_cnt_q,  flush_cnt_d;
  logic [SCW-1:0]       samp_cnt_q,   samp_cnt_d;
  logic [OUT_WIDTH-1:0] data_q,       data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 data_last_q,  data_last_d;

  logic                 zoom_accept;
  logic [3:0]           zoom_clamped;
  logic [FCW-1:0]       flush_inc;
  logic [SCW-1:0]       samp_inc;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge, whatever order the statements
  // are written in.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      zoom_q       <= ZOOM_RESET;
      flush_cnt_q  <= '0;
      samp_cnt_q   <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      data_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      zoom_q       <= zoom_d;
      flush_cnt_q  <= flush_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      data_last_q  <= data_last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  assign zoom_accept  = s_axis_zoom_tvalid & s_axis_zoom_tready;
  assign zoom_clamped = (s_axis_zoom_tdata > ZOOM_MAX_C) ? ZOOM_MAX_C : s_axis_zoom_tdata;
  assign flush_inc    = flush_cnt_q + FCW'(1);
  assign samp_inc     = samp_cnt_q + SCW'(1);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    zoom_d       = zoom_q;
    flush_cnt_d  = flush_cnt_q;
    samp_cnt_d   = samp_cnt_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    data_last_d  = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        if (m_axis_config_tready) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end
      end

      // The CIC output is garbage until its pipeline has filled with samples
      // taken at the new rate. Count those samples and drop them.
      ST_FLUSH: begin
        if (cic_tvalid) begin
          flush_cnt_d = flush_inc;
          if (flush_inc == FLUSH_LAST) begin
            state_d = ST_READY;
          end
        end
      end

      // A zoom request has priority over start. The start pulse is dropped,
      // not remembered.
      ST_READY: begin
        if (zoom_accept) begin
          state_d = ST_LOAD;
          zoom_d  = zoom_clamped;
        end else if (start) begin
          state_d    = ST_CAPTURE;
          samp_cnt_d = '0;
        end
      end

      // A zoom request aborts the frame. A strobe in the same cycle is not
      // captured. The output already sitting in data_q still goes out,
      // because data_valid_q is not touched here.
      ST_CAPTURE: begin
        if (zoom_accept) begin
          state_d = ST_LOAD;
          zoom_d  = zoom_clamped;
        end else if (cic_tvalid) begin
          data_d       = cic_tdata;
          data_valid_d = 1'b1;
          samp_cnt_d   = samp_inc;
          if (samp_inc == FRAME_LAST) begin
            data_last_d = 1'b1;
            state_d     = ST_READY;
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  // Reset is synchronous, but the outputs must show their reset values in
  // every cycle that reset is high. That includes the first cycle, before any
  // edge has cleared the flops. The outputs are therefore also gated directly
  // by reset.
  always_comb begin
    s_axis_zoom_tready   = 1'b0;
    m_axis_config_tvalid = 1'b0;
    busy                 = 1'b1;

    if (!reset) begin
      unique case (state_q)
        ST_LOAD:    m_axis_config_tvalid = 1'b1;
        ST_FLUSH:   busy                 = 1'b1;
        ST_READY: begin
          s_axis_zoom_tready = 1'b1;
          busy               = 1'b0;
        end
        ST_CAPTURE: s_axis_zoom_tready = 1'b1;
        default:    busy               = 1'b1;
      endcase
    end

    // zoom_q changes only when a request is accepted. No request is accepted
    // in LOAD, so the word stays stable for the whole handshake.
    m_axis_config_tdata = CFG_ONE << (zoom_q + 5'd1);

    m_axis_data_tdata  = reset ? '0         : data_q;
    m_axis_data_tvalid = reset ? 1'b0       : data_valid_q;
    m_axis_data_tlast  = reset ? 1'b0       : data_last_q;
    zoom               = reset ? ZOOM_RESET : zoom_q;
  end

endmodule

// File: doc/kiwi_wf_ctrl.md
KIWI_WF_CTRL -- requirements
Module: kiwi_wf_ctrl

Interface
REQ-001 SHALL have parameter ZOOM_MAX, default 13, highest accepted zoom level.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, sample width of the CIC output and data output.
REQ-003 SHALL have parameter CFG_WIDTH, default 24, width of the decimation config word.
REQ-004 SHALL have parameter FLUSH_SAMPLES, default 6, number of CIC outputs discarded after each reconfiguration.
REQ-005 SHALL have parameter FRAME_LEN, default 1024, samples per capture frame.
REQ-006 SHALL have port aclk  in  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports s_axis_zoom_tdata in 4, s_axis_zoom_tvalid in 1, s_axis_zoom_tready out 1: zoom-level request stream.
REQ-009 SHALL have ports m_axis_config_tdata out CFG_WIDTH, m_axis_config_tvalid out 1, m_axis_config_tready in 1: decimation word to the CIC config port.
REQ-010 SHALL have ports cic_tdata in OUT_WIDTH, cic_tvalid in 1: CIC output samples; cic_tvalid is a single-cycle strobe; there is no backpressure.
REQ-011 SHALL have ports m_axis_data_tdata out OUT_WIDTH, m_axis_data_tvalid out 1, m_axis_data_tlast out 1: captured frame samples, no tready.
REQ-012 SHALL have ports start in 1 (capture request), busy out 1, zoom out 4 (currently applied zoom).

Function
REQ-013 SHALL implement states LOAD, FLUSH, READY, CAPTURE.
REQ-014 Decimation word SHALL be 2^(z+1), zero-extended to CFG_WIDTH (z=0 -> 2, z=4 -> 32, z=13 -> 16384).
REQ-015 A requested zoom above ZOOM_MAX SHALL be clamped to ZOOM_MAX before use.
REQ-016 s_axis_zoom_tready SHALL be high only in READY and CAPTURE; a request is accepted when tvalid and tready are both high.
REQ-017 On an accepted request, the next cycle SHALL enter LOAD with zoom updated to the clamped value.
REQ-018 In LOAD, m_axis_config_tvalid SHALL be high and tdata SHALL hold the decimation word, both stable until m_axis_config_tready is seen high.
REQ-019 The LOAD handshake cycle SHALL move to FLUSH with the flush counter cleared; m_axis_config_tvalid SHALL be low in every other state.
REQ-020 In FLUSH, each cic_tvalid strobe SHALL increment the counter; the strobe bringing it to FLUSH_SAMPLES SHALL move to READY on the next cycle.
REQ-021 CIC samples arriving in LOAD, FLUSH or READY SHALL be discarded; m_axis_data_tvalid SHALL stay low.
REQ-022 In READY, start high SHALL move to CAPTURE with the sample counter cleared; start in any other state SHALL be ignored and not queued.
REQ-023 If start and an accepted zoom request coincide in READY, the zoom request SHALL win and start SHALL be dropped.
REQ-024 In CAPTURE, each cic_tvalid strobe SHALL produce m_axis_data_tvalid one cycle later with the registered cic_tdata (latency 1).
REQ-025 m_axis_data_tlast SHALL be high with the FRAME_LEN-th output sample only; CAPTURE SHALL then return to READY.
REQ-026 An accepted zoom request in CAPTURE SHALL abort the frame: no further samples and no tlast; an output already registered in that cycle SHALL still be emitted.
REQ-027 busy SHALL be high in every state except READY.
REQ-028 All counters SHALL be sized to hold FRAME_LEN and FLUSH_SAMPLES without wrap-around.

Reset
REQ-029 Reset high SHALL force LOAD with zoom = 4 (decimation 32), regardless of the current state, including mid-capture or mid-handshake.
REQ-030 During reset, outputs SHALL be: m_axis_config_tvalid 0, m_axis_data_tvalid 0, m_axis_data_tlast 0, m_axis_data_tdata 0, s_axis_zoom_tready 0, busy 1, zoom 4.
REQ-031 All counters SHALL be cleared by reset.
REQ-032 The first cycle after reset release SHALL present config tvalid=1 with tdata=32.

Verification
REQ-033 Reset release, config tready held high, feed 6 cic strobes -> one config beat with tdata=32; busy falls after the 6th strobe; no data output.
REQ-034 In READY, zoom request 9 -> config tdata=1024; tvalid held across 5 cycles of tready=0 with stable data; zoom=9.
REQ-035 Zoom request 15 -> clamped; config tdata=16384; zoom=13.
REQ-036 Start in READY, then 1024 strobes with tdata = index -> 1024 outputs, each 1 cycle after its strobe, data 0..1023; tlast only on 1023; busy low afterward.
REQ-037 Zoom request after the 100th strobe of a capture -> at most 100 outputs, no tlast, LOAD entered; start pulses during FLUSH are ignored.
REQ-038 Reset asserted mid-capture -> next cycle all data outputs 0, config tvalid=1 with tdata=32.
